// File: rtl/rnn_matvec.sv
// rnn_matvec: column-at-a-time matrix-vector product out[c] = sat16(sum_r x[r]*W[r][c]).
// Define RNN_MATVEC_RELU_EN to clamp negative results to zero on the output.
module rnn_matvec #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 4,
  parameter int ACC_W = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               x_rd_en,
  output logic [7:0]         x_idx,
  input  logic signed [15:0] x_data,
  output logic               w_rd_en,
  output logic [7:0]         w_row,
  output logic [7:0]         w_col,
  input  logic signed [15:0] w_data,
  output logic               out_valid,
  output logic [7:0]         out_idx,
  output logic signed [15:0] out_data,
  input  logic               out_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] LAST = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  localparam logic [7:0] R_LAST = 8'(N_IN - 1);
  localparam logic [7:0] C_LAST = 8'(N_OUT - 1);

  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = ACC_W'(32'sd32767);
    lo = ACC_W'(-32'sd32768);
    if (v > hi) begin
      return 16'sh7fff;
    end else if (v < lo) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

  function automatic logic signed [15:0] out_value(input logic signed [ACC_W-1:0] v);
    logic signed [15:0] s;
    s = sat16(v);
`ifdef RNN_MATVEC_RELU_EN
    return s[15] ? 16'sd0 : s;
`else
    return s;
`endif
  endfunction

  logic [1:0]               state_r, state_s;
  logic [7:0]               r_r, r_s;
  logic [7:0]               c_r, c_s;
  logic signed [ACC_W-1:0]  acc_r, acc_s;
  logic                     busy_r, busy_s;
  logic                     done_r, done_s;
  logic                     rd_en_r, rd_en_s;
  logic                     pend_r;
  logic                     out_valid_r, out_valid_s;
  logic [7:0]               out_idx_r, out_idx_s;
  logic signed [15:0]       out_data_r, out_data_s;
  logic signed [31:0]       prod_s;
  logic signed [ACC_W-1:0]  acc_sum_s;

  assign prod_s    = 32'(x_data) * 32'(w_data);
  assign acc_sum_s = acc_r + ACC_W'(prod_s);

  // Next-state and next-output decode; read data is folded in the cycle after its request.
  always_comb begin
    state_s     = state_r;
    r_s         = r_r;
    c_s         = c_r;
    acc_s       = acc_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    rd_en_s     = 1'b0;
    out_valid_s = out_valid_r;
    out_idx_s   = out_idx_r;
    out_data_s  = out_data_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
          r_s     = 8'd0;
          c_s     = 8'd0;
          acc_s   = {ACC_W{1'b0}};
          busy_s  = 1'b1;
          rd_en_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (pend_r) begin
          acc_s = acc_sum_s;
        end else begin
          acc_s = acc_r;
        end
        if (r_r == R_LAST) begin
          state_s = LAST;
        end else begin
          r_s     = r_r + 8'd1;
          rd_en_s = 1'b1;
        end
      end
      LAST: begin
        acc_s       = acc_sum_s;
        out_data_s  = out_value(acc_sum_s);
        out_idx_s   = c_r;
        out_valid_s = 1'b1;
        state_s     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          if (c_r == C_LAST) begin
            state_s = IDLE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            c_s     = c_r + 8'd1;
            r_s     = 8'd0;
            acc_s   = {ACC_W{1'b0}};
            rd_en_s = 1'b1;
            state_s = RUN;
          end
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s     = IDLE;
        busy_s      = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      r_r         <= 8'd0;
      c_r         <= 8'd0;
      acc_r       <= {ACC_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      pend_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_idx_r   <= 8'd0;
      out_data_r  <= 16'sd0;
    end else begin
      state_r     <= state_s;
      r_r         <= r_s;
      c_r         <= c_s;
      acc_r       <= acc_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      rd_en_r     <= rd_en_s;
      pend_r      <= rd_en_r;
      out_valid_r <= out_valid_s;
      out_idx_r   <= out_idx_s;
      out_data_r  <= out_data_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign x_rd_en   = rd_en_r;
  assign w_rd_en   = rd_en_r;
  assign x_idx     = r_r;
  assign w_row     = r_r;
  assign w_col     = c_r;
  assign out_valid = out_valid_r;
  assign out_idx   = out_idx_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_rnn_matvec.sv
// tb_rnn_matvec: table-driven and randomized checks of rnn_matvec against an arithmetic model.
// Expected values follow RNN_MATVEC_RELU_EN when that macro is defined.
module tb_rnn_matvec;
  localparam int N_IN  = 2;
  localparam int N_OUT = 4;
  localparam int ACC_W = 40;

  logic clk = 1'b0;
  logic rst, start, busy, done, x_rd_en, w_rd_en, out_valid, out_ready;
  logic [7:0] x_idx, w_row, w_col, out_idx;
  logic signed [15:0] x_data, w_data, out_data;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int got_idx[$];
  int got_data[$];

  logic signed [15:0] xm [N_IN];
  logic signed [15:0] wm [N_IN][N_OUT];

  typedef struct {
    logic [N_IN-1:0][15:0]             x;
    logic [N_IN-1:0][N_OUT-1:0][15:0]  w;
    logic [N_OUT-1:0][15:0]            e;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  rnn_matvec #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .x_rd_en(x_rd_en), .x_idx(x_idx), .x_data(x_data),
    .w_rd_en(w_rd_en), .w_row(w_row), .w_col(w_col), .w_data(w_data),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data), .out_ready(out_ready)
  );

  // Read-port memories: one-cycle latency, garbage when not read.
  always @(posedge clk) begin
    x_data <= x_rd_en ? xm[x_idx] : 16'($urandom);
    w_data <= w_rd_en ? wm[w_row][w_col] : 16'($urandom);
  end

  // Output stream logger and read-while-valid watch.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        got_idx.push_back(int'(out_idx));
        got_data.push_back(int'(out_data));
      end
      if (done) done_cnt++;
      if (out_valid) begin
        checks++;
        if (x_rd_en || w_rd_en) begin
          failures++;
          $display("FAIL read_during_out: x_rd_en=%0b w_rd_en=%0b required 0", x_rd_en, w_rd_en);
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_idx.delete();
    got_data.delete();
    done_cnt = 0;
  endtask

  function automatic int model_out(input int c);
    longint s = 0;
    for (int r = 0; r < N_IN; r++) s += longint'(xm[r]) * longint'(wm[r][c]);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`ifdef RNN_MATVEC_RELU_EN
    if (s < 0) s = 0;
`endif
    return int'(s);
  endfunction

  task automatic load_vec(input int i, output int e [N_OUT]);
    for (int r = 0; r < N_IN; r++) begin
      xm[r] = vecs[i].x[r];
      for (int c = 0; c < N_OUT; c++) wm[r][c] = vecs[i].w[r][c];
    end
    for (int c = 0; c < N_OUT; c++) e[c] = int'($signed(vecs[i].e[c]));
  endtask

  task automatic set_row(input int i, input int r, input int a, input int b, input int c, input int d);
    vecs[i].w[r][0] = 16'(a);
    vecs[i].w[r][1] = 16'(b);
    vecs[i].w[r][2] = 16'(c);
    vecs[i].w[r][3] = 16'(d);
  endtask

  task automatic set_exp(input int i, input int a, input int b, input int c, input int d);
    vecs[i].e[0] = 16'(a);
    vecs[i].e[1] = 16'(b);
    vecs[i].e[2] = 16'(c);
    vecs[i].e[3] = 16'(d);
  endtask

  task automatic finish_pass(input int ready_pct);
    int cyc = 0;
    while (!done && cyc < 400) begin
      out_ready = ($urandom_range(0, 99) < ready_pct);
      step();
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL pass_timeout: done not seen after %0d cycles", cyc);
    end
  endtask

  task automatic check_seq(input string name, input int exp [N_OUT]);
    check({name, "_count"}, got_idx.size(), N_OUT);
    for (int i = 0; i < N_OUT; i++) begin
      if (i < got_idx.size()) begin
        check({name, "_idx"}, got_idx[i], i);
        check({name, "_data"}, got_data[i], exp[i]);
      end else begin
        checks++;
        failures++;
        $display("FAIL %s_missing: output %0d absent, required %0d", name, i, exp[i]);
      end
    end
    check({name, "_done"}, done_cnt, 1);
  endtask

  initial begin
    int e [N_OUT];
    int lat;
    int cyc;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    for (int r = 0; r < N_IN; r++) begin
      xm[r] = 16'sd0;
      for (int c = 0; c < N_OUT; c++) wm[r][c] = 16'sd0;
    end

    vecs[0].x[0] = 16'(2);     vecs[0].x[1] = 16'(-3);
    set_row(0, 0, 2, -10, -10, 3);
    set_row(0, 1, 6, 9, 12, 1);
    vecs[1].x[0] = 16'(32767); vecs[1].x[1] = 16'(32767);
    set_row(1, 0, 32767, 32767, 32767, 32767);
    set_row(1, 1, 32767, 32767, 32767, 32767);
    set_exp(1, 32767, 32767, 32767, 32767);
    vecs[2].x[0] = 16'(-32768); vecs[2].x[1] = 16'(-32768);
    set_row(2, 0, 32767, 32767, 32767, 32767);
    set_row(2, 1, 32767, 32767, 32767, 32767);
    vecs[3].x[0] = 16'(1);     vecs[3].x[1] = 16'(1);
    set_row(3, 0, -32768, 32767, 100, -1);
    set_row(3, 1, -32768, 1, -200, 1);
`ifdef RNN_MATVEC_RELU_EN
    set_exp(0, 0, 0, 0, 3);
    set_exp(2, 0, 0, 0, 0);
    set_exp(3, 0, 32767, 0, 0);
`else
    set_exp(0, -14, -47, -56, 3);
    set_exp(2, -32768, -32768, -32768, -32768);
    set_exp(3, -32768, 32767, -100, 0);
`endif

    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_x_rd_en", x_rd_en, 0);
    check("rst_w_rd_en", w_rd_en, 0);
    check("rst_x_idx", x_idx, 0);
    check("rst_w_row", w_row, 0);
    check("rst_w_col", w_col, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      load_vec(i, e);
      clear_log();
      start = 1'b1; step(); start = 1'b0;
      finish_pass(100);
      step(); step(); step();
      check_seq($sformatf("table%0d", i), e);
    end

    // Latency and back-pressure on the first result.
    load_vec(0, e);
    clear_log();
    start = 1'b1; step(); start = 1'b0;
    check("start_busy", busy, 1);
    lat = 0;
    while (!out_valid && lat < 50) begin step(); lat++; end
    check("first_latency", lat, N_IN + 1);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, e[0]);
      check("hold_idx", out_idx, 0);
      check("hold_x_rd_en", x_rd_en, 0);
      check("hold_w_rd_en", w_rd_en, 0);
      step();
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin step(); lat++; end
    check("col_latency", lat, N_IN + 1);
    finish_pass(100);
    step(); step(); step();
    check_seq("backpressure", e);

    // Second start while busy must be ignored.
    load_vec(0, e);
    clear_log();
    start = 1'b1; step(); start = 1'b0;
    step();
    start = 1'b1; step(); start = 1'b0;
    finish_pass(100);
    repeat (10) step();
    check("dbl_busy_after", busy, 0);
    check_seq("double_start", e);

    // Reset in the middle of column 1, then an immediate fresh pass.
    load_vec(3, e);
    clear_log();
    start = 1'b1; step(); start = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (got_idx.size() < 1 && cyc < 50) begin step(); cyc++; end
    check("midreset_col0_seen", got_idx.size(), 1);
    step();
    rst = 1'b1; step();
    out_ready = 1'b0;
    check("midreset_busy", busy, 0);
    check("midreset_valid", out_valid, 0);
    check("midreset_done", done, 0);
    check("midreset_x_rd_en", x_rd_en, 0);
    check("midreset_out_data", out_data, 0);
    clear_log();
    rst = 1'b0; start = 1'b1; step(); start = 1'b0;
    finish_pass(100);
    repeat (5) step();
    check_seq("after_reset", e);

    // Start in the cycle done is high begins a new pass.
    load_vec(0, e);
    clear_log();
    start = 1'b1; step(); start = 1'b0;
    finish_pass(100);
    start = 1'b1; step(); start = 1'b0;
    check("b2b_busy", busy, 1);
    check_seq("b2b_first", e);
    load_vec(3, e);
    clear_log();
    finish_pass(100);
    step(); step(); step();
    check_seq("b2b_second", e);

    // Randomized passes against the arithmetic model.
    for (int t = 0; t < 8; t++) begin
      for (int r = 0; r < N_IN; r++) begin
        xm[r] = (t % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 600)) - 16'd300;
        for (int c = 0; c < N_OUT; c++)
          wm[r][c] = (t % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 600)) - 16'd300;
      end
      for (int c = 0; c < N_OUT; c++) e[c] = model_out(c);
      clear_log();
      start = 1'b1; step(); start = 1'b0;
      finish_pass(50);
      step(); step(); step();
      check_seq($sformatf("random%0d", t), e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rnn_matvec.md
RNN_MATVEC -- requirements
Module: rnn_matvec

Interface
REQ-001 The block SHALL have parameter N_IN, default 2, meaning input-vector length (rows of W), range 1..256.
REQ-002 The block SHALL have parameter N_OUT, default 4, meaning output-vector length (columns of W), range 1..256.
REQ-003 The block SHALL have parameter ACC_W, default 40, meaning accumulator width in bits, at least 32+clog2(N_IN).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: request one full matrix-vector pass.
REQ-007 The block SHALL have ports busy and done, outputs, 1 bit each: busy = pass in progress; done = one-cycle pulse at pass end.
REQ-008 The block SHALL have ports x_rd_en (output, 1), x_idx (output, 8) and x_data (input, 16 signed): input-vector read port, data valid one cycle after x_rd_en.
REQ-009 The block SHALL have ports w_rd_en (output, 1), w_row (output, 8), w_col (output, 8) and w_data (input, 16 signed): weight-matrix read port, data valid one cycle after w_rd_en.
REQ-010 The block SHALL have ports out_valid (output, 1), out_idx (output, 8), out_data (output, 16 signed) and out_ready (input, 1): result stream.

Function
REQ-011 The block SHALL compute out[c] = sat16( sum over r of x[r]*W[r][c] ) for c = 0..N_OUT-1, emitted in ascending c.
REQ-012 Each product SHALL be a full 32-bit signed value, and the accumulator SHALL be ACC_W bits signed with no intermediate wrap.
REQ-013 sat16 SHALL clamp the result to [-32768, 32767].
REQ-014 The FSM SHALL have four states: IDLE, RUN, LAST and OUT.
REQ-015 In IDLE with start=1, the FSM SHALL set r=0, c=0, acc=0, assert busy, and go to RUN.
REQ-016 In IDLE with start=0, the FSM SHALL stay in IDLE.
REQ-017 In RUN, the block SHALL assert x_rd_en and w_rd_en with x_idx=r, w_row=r, w_col=c, and SHALL add the product returned for the previous read to acc.
REQ-018 When r=N_IN-1 in RUN, the FSM SHALL go to LAST.
REQ-019 In LAST, the block SHALL add the final product, register sat16(acc) into out_data with out_idx=c, and go to OUT.
REQ-020 In OUT, the block SHALL hold out_valid=1 with out_data and out_idx stable, and SHALL issue no reads.
REQ-021 In OUT, on out_valid and out_ready both high with c<N_OUT-1, the block SHALL increment c, clear r and acc, and go to RUN.
REQ-022 In OUT, on out_valid and out_ready both high with c=N_OUT-1, the block SHALL pulse done for one cycle, deassert busy, and go to IDLE.
REQ-023 out_valid SHALL first rise N_IN+1 cycles after start is sampled.
REQ-024 Each subsequent column SHALL take N_IN+1 cycles after the handshake.
REQ-025 start while busy=1 SHALL be ignored, with no restart and no queuing.
REQ-026 The block SHALL return to IDLE on the same edge as done, so a start sampled in the cycle after done SHALL begin a new pass.
REQ-027 x_rd_en and w_rd_en SHALL be 0 in all states other than RUN.

Reset
REQ-028 With rst=1 at a rising edge, the block SHALL enter IDLE and clear r, c and acc.
REQ-029 With rst=1 at a rising edge, busy, done, out_valid, x_rd_en and w_rd_en SHALL be 0, and x_idx, w_row, w_col, out_idx and out_data SHALL be 0.
REQ-030 Reset mid-pass SHALL abort the pass with no done pulse and no further out_valid.
REQ-031 A read return arriving in the cycle after reset SHALL be discarded.

Configuration
REQ-032 With macro RNN_MATVEC_RELU_EN defined, out_data SHALL be max(0, sat16(acc)), with negative results emitted as 0.
REQ-033 Without RNN_MATVEC_RELU_EN, out_data SHALL be sat16(acc) unmodified, and no ReLU logic SHALL be present.

Verification
REQ-034 Bench: x=[2,-3], W row0={2,-10,-10,3}, row1={6,9,12,1}, out_ready=1, macro undefined -> outputs (idx,data) (0,-14) (1,-47) (2,-56) (3,3), then one done pulse.
REQ-035 Bench: same stimulus with RNN_MATVEC_RELU_EN defined -> outputs 0, 0, 0, 3.
REQ-036 Bench: x=[32767,32767] with all W=32767 -> every output 32767; x=[-32768,-32768] with all W=32767 -> every output -32768.
REQ-037 Bench: out_ready held low 5 cycles on the first result -> out_valid stays 1, out_data stays -14, reads stay deasserted, and the next result is unaffected.
REQ-038 Bench: start pulsed again 2 cycles after the first start -> exactly one pass of 4 outputs.
REQ-039 Bench: rst asserted during column 1 -> next cycle busy=0 and out_valid=0 with no done pulse; a fresh start then gives the full correct sequence.
